// File: rtl/adc_capture_seq.sv
// Acquisition sequencer for one 8-bit ADC channel: pre-trigger fill, edge/force/auto trigger,
// then a post-trigger window written into a circular sample RAM.
module adc_capture_seq #(
  parameter int ADDR_W    = 12,
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           adc_data,
  input  logic                 adc_valid,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [7:0]           trig_level,
  input  logic                 trig_rising,
  input  logic                 trig_force,
  input  logic                 auto_en,
  input  logic [TIMEOUT_W-1:0] auto_timeout,
  input  logic [ADDR_W-1:0]    pre_len,
  input  logic [ADDR_W-1:0]    post_len,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [7:0]           wr_data,
  output logic [ADDR_W-1:0]    trig_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 trig_auto
);

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

  state_t               state_q, state_d;
  logic [7:0]           level_q, level_d;
  logic                 rising_q, rising_d;
  logic                 auto_en_q, auto_en_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [ADDR_W-1:0]    pre_len_q, pre_len_d;
  logic [ADDR_W-1:0]    post_len_q, post_len_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
  logic                 force_q, force_d;
  logic [7:0]           prev_q, prev_d;
  logic                 prev_vld_q, prev_vld_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]    trig_addr_q, trig_addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 trig_auto_q, trig_auto_d;

  logic                 start;
  logic                 capture;
  logic                 rise_hit;
  logic                 fall_hit;
  logic                 edge_hit;
  logic                 force_hit;
  logic                 auto_hit;
  logic [ADDR_W-1:0]    cnt_inc;

  assign start     = arm && (state_q == IDLE || state_q == DONE);
  assign capture   = adc_valid && (state_q == PRE || state_q == WAIT_TRIG || state_q == POST);
  assign cnt_inc   = cnt_q + 1'b1;
  // Edge detection needs a previous sample from this acquisition, so the first one never fires.
  assign rise_hit  = prev_vld_q && (prev_q < level_q) && (adc_data >= level_q);
  assign fall_hit  = prev_vld_q && (prev_q > level_q) && (adc_data <= level_q);
  assign edge_hit  = rising_q ? rise_hit : fall_hit;
  assign force_hit = force_q || trig_force;
  assign auto_hit  = auto_en_q && (tcnt_q >= timeout_q);

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    rising_d    = rising_q;
    auto_en_d   = auto_en_q;
    timeout_d   = timeout_q;
    pre_len_d   = pre_len_q;
    post_len_d  = post_len_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    force_d     = force_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    ptr_d       = ptr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    trig_addr_d = trig_addr_q;
    trig_auto_d = trig_auto_q;

    if (abort) begin
      state_d = IDLE;
    end else if (start) begin
      level_d     = trig_level;
      rising_d    = trig_rising;
      auto_en_d   = auto_en;
      timeout_d   = auto_timeout;
      pre_len_d   = pre_len;
      post_len_d  = post_len;
      cnt_d       = '0;
      tcnt_d      = '0;
      force_d     = 1'b0;
      prev_vld_d  = 1'b0;
      ptr_d       = '0;
      wr_addr_d   = '0;
      trig_auto_d = 1'b0;
      state_d     = (pre_len == '0) ? WAIT_TRIG : PRE;
    end else begin
      if (capture) begin
        wr_en_d    = 1'b1;
        wr_addr_d  = ptr_q;
        wr_data_d  = adc_data;
        ptr_d      = ptr_q + 1'b1;
        prev_d     = adc_data;
        prev_vld_d = 1'b1;
      end

      case (state_q)
        PRE: begin
          if (adc_valid) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pre_len_q) begin
              cnt_d   = '0;
              tcnt_d  = '0;
              force_d = 1'b0;
              state_d = WAIT_TRIG;
            end
          end
        end
        WAIT_TRIG: begin
          // Timeout counter runs on clock cycles, not samples, and saturates.
          if (tcnt_q != {TIMEOUT_W{1'b1}}) tcnt_d = tcnt_q + 1'b1;
          if (trig_force) force_d = 1'b1;
          if (adc_valid && (edge_hit || force_hit || auto_hit)) begin
            trig_addr_d = ptr_q;
            trig_auto_d = !edge_hit && !force_hit;
            cnt_d       = '0;
            state_d     = (post_len_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (adc_valid) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_len_q) state_d = DONE;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == PRE) || (state_d == WAIT_TRIG) || (state_d == POST);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      level_q     <= '0;
      rising_q    <= 1'b0;
      auto_en_q   <= 1'b0;
      timeout_q   <= '0;
      pre_len_q   <= '0;
      post_len_q  <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      force_q     <= 1'b0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      ptr_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      trig_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_auto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      rising_q    <= rising_d;
      auto_en_q   <= auto_en_d;
      timeout_q   <= timeout_d;
      pre_len_q   <= pre_len_d;
      post_len_q  <= post_len_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      force_q     <= force_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      ptr_q       <= ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      trig_addr_q <= trig_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      trig_auto_q <= trig_auto_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign trig_addr = trig_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_auto = trig_auto_q;

endmodule

// File: tb/tb_adc_capture_seq.sv
// Self-checking bench for adc_capture_seq: edge table, directed multi-cycle sequences,
// and randomized acquisitions scored against a transaction-level model of the capture rules.
module tb_adc_capture_seq;
  localparam int AW   = 4;
  localparam int TW   = 8;
  localparam int NMAX = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    adc_data;
  logic          adc_valid;
  logic          arm;
  logic          abort;
  logic [7:0]    trig_level;
  logic          trig_rising;
  logic          trig_force;
  logic          auto_en;
  logic [TW-1:0] auto_timeout;
  logic [AW-1:0] pre_len;
  logic [AW-1:0] post_len;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] trig_addr;
  logic          busy;
  logic          done;
  logic          trig_auto;

  adc_capture_seq #(.ADDR_W(AW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .arm(arm), .abort(abort),
    .trig_level(trig_level), .trig_rising(trig_rising), .trig_force(trig_force), .auto_en(auto_en),
    .auto_timeout(auto_timeout), .pre_len(pre_len), .post_len(post_len), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .trig_addr(trig_addr), .busy(busy), .done(done),
    .trig_auto(trig_auto)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int idx; } wr_t;
  typedef struct { logic [7:0] prev; logic [7:0] cur; logic [7:0] level; bit rising; bit trig; } edge_vec_t;

  wr_t        obs_q[$];
  wr_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         s_vld[NMAX];
  logic [7:0] s_dat[NMAX];
  bit         s_frc[NMAX];
  bit         s_arm[NMAX];
  int         c_pre, c_post, c_tmo;
  logic [7:0] c_level;
  bit         c_rising, c_auto;
  int         obs_done_idx, exp_done_idx, exp_taddr;
  bit         exp_tauto, exp_trig;
  edge_vec_t  tbl[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    adc_valid = 1'b0; adc_data = 8'h00; arm = 1'b0; abort = 1'b0; trig_force = 1'b0;
  endtask

  task automatic clearStim();
    for (int i = 0; i < NMAX; i++) begin
      s_vld[i] = 1'b0; s_dat[i] = 8'h00; s_frc[i] = 1'b0; s_arm[i] = 1'b0;
    end
  endtask

  task automatic driveConfig();
    trig_level = c_level; trig_rising = c_rising; auto_en = c_auto;
    auto_timeout = TW'(c_tmo); pre_len = AW'(c_pre); post_len = AW'(c_post);
  endtask

  // Reference: walk the sample stream through pre-fill, trigger search and post-fill.
  task automatic modelRun(input int ncyc);
    int phase, npre, npost, nw, w0;
    bit have_prev, force_seen, is_edge;
    logic [7:0] prev, cur;
    wr_t w;
    exp_q.delete(); exp_done_idx = -1; exp_trig = 0; exp_tauto = 0; exp_taddr = 0;
    phase = (c_pre == 0) ? 1 : 0; w0 = 1; npre = 0; npost = 0; nw = 0;
    have_prev = 0; force_seen = 0; prev = 8'h00;
    for (int i = 1; i <= ncyc; i++) begin
      if (phase == 3) break;
      if (phase == 1 && s_frc[i]) force_seen = 1;
      if (s_vld[i]) begin
        cur = s_dat[i];
        w.addr = nw % (1 << AW); w.data = int'(cur); w.idx = i;
        exp_q.push_back(w);
        if (phase == 0) begin
          npre++;
          if (npre == c_pre) begin phase = 1; w0 = i + 1; end
        end else if (phase == 1) begin
          if (c_rising) is_edge = have_prev && (prev < c_level) && (cur >= c_level);
          else          is_edge = have_prev && (prev > c_level) && (cur <= c_level);
          if (is_edge || force_seen || (c_auto && (i - w0) >= c_tmo)) begin
            exp_trig = 1; exp_taddr = nw % (1 << AW); exp_tauto = !is_edge && !force_seen;
            if (c_post == 0) begin phase = 3; exp_done_idx = i; end
            else begin phase = 2; npost = 0; end
          end
        end else begin
          npost++;
          if (npost == c_post) begin phase = 3; exp_done_idx = i; end
        end
        nw++; prev = cur; have_prev = 1;
      end
    end
  endtask

  // Arm, then play the stimulus arrays; observation index i means "after the edge of cycle i".
  task automatic applyStimulus(input int ncyc);
    wr_t w;
    tick();
    driveConfig();
    idleInputs();
    arm = 1'b1;
    obs_q.delete(); obs_done_idx = -1;
    for (int i = 1; i <= ncyc + 1; i++) begin
      tick();
      if (wr_en) begin
        w.addr = int'(wr_addr); w.data = int'(wr_data); w.idx = i - 1;
        obs_q.push_back(w);
      end
      if (done && obs_done_idx < 0) obs_done_idx = i - 1;
      trig_level = 8'($urandom); trig_rising = 1'($urandom_range(0, 1));
      auto_en = 1'($urandom_range(0, 1)); auto_timeout = TW'($urandom);
      pre_len = AW'($urandom); post_len = AW'($urandom);
      if (i <= ncyc) begin
        adc_valid = s_vld[i]; adc_data = s_dat[i]; trig_force = s_frc[i]; arm = s_arm[i];
      end else begin
        idleInputs();
      end
    end
  endtask

  task automatic runAcq(input string name, input int ncyc);
    int n;
    modelRun(ncyc);
    applyStimulus(ncyc);
    checkOutput({name, "_nwrites"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      checkOutput({name, "_write"}, (obs_q[k].idx << 16) | (obs_q[k].addr << 8) | obs_q[k].data,
                  (exp_q[k].idx << 16) | (exp_q[k].addr << 8) | exp_q[k].data);
    checkOutput({name, "_done_idx"}, obs_done_idx, exp_done_idx);
    checkOutput({name, "_busy"}, busy, exp_done_idx < 0);
    checkOutput({name, "_done"}, done, exp_done_idx >= 0);
    checkOutput({name, "_trig_auto"}, trig_auto, exp_tauto);
    if (exp_trig) checkOutput({name, "_trig_addr"}, trig_addr, exp_taddr);
  endtask

  task automatic endAcq();
    if (busy) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wcount;
    rst = 1'b1;
    idleInputs();
    c_pre = 0; c_post = 0; c_tmo = 0; c_level = 8'h00; c_rising = 1'b0; c_auto = 1'b0;
    driveConfig();
    repeat (3) tick();
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_trig_addr", trig_addr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_trig_auto", trig_auto, 0);
    rst = 1'b0;
    tick();

    tbl[0] = '{8'h50, 8'h40, 8'h40, 1'b0, 1'b1};
    tbl[1] = '{8'h50, 8'h40, 8'h40, 1'b1, 1'b0};
    tbl[2] = '{8'h30, 8'h40, 8'h40, 1'b1, 1'b1};
    tbl[3] = '{8'h40, 8'h50, 8'h40, 1'b1, 1'b0};
    tbl[4] = '{8'h40, 8'h30, 8'h40, 1'b0, 1'b0};
    tbl[5] = '{8'h7f, 8'h80, 8'h80, 1'b1, 1'b1};
    tbl[6] = '{8'h00, 8'hff, 8'hff, 1'b1, 1'b1};
    tbl[7] = '{8'hff, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[8] = '{8'h10, 8'h20, 8'h80, 1'b1, 1'b0};
    for (int v = 0; v < 9; v++) begin
      c_pre = 0; c_post = 0; c_auto = 0; c_tmo = 0;
      c_level = tbl[v].level; c_rising = tbl[v].rising;
      clearStim();
      s_vld[1] = 1'b1; s_dat[1] = tbl[v].prev;
      s_vld[2] = 1'b1; s_dat[2] = tbl[v].cur;
      runAcq("tbl", 4);
      checkOutput("tbl_done", done, tbl[v].trig);
      if (tbl[v].trig) checkOutput("tbl_trig_addr", trig_addr, 1);
      endAcq();
    end

    // Rising ramp: the 0x78 -> 0x80 crossing is the first sample after the pre window.
    c_pre = 4; c_post = 3; c_level = 8'h80; c_rising = 1'b1; c_auto = 1'b0; c_tmo = 0;
    clearStim();
    for (int i = 1; i <= 12; i++) begin s_vld[i] = 1'b1; s_dat[i] = 8'(8'h60 + 8 * (i - 1)); end
    runAcq("ramp", 12);
    checkOutput("ramp_trig_addr", trig_addr, 4);
    checkOutput("ramp_done_idx", obs_done_idx, 8);
    endAcq();

    c_pre = 2; c_post = 3; c_level = 8'h80; c_rising = 1'b1; c_auto = 1'b1; c_tmo = 100;
    clearStim();
    for (int i = 1; i <= 130; i++) begin s_vld[i] = 1'b1; s_dat[i] = 8'h10; end
    runAcq("auto", 130);
    checkOutput("auto_trig_auto", trig_auto, 1);
    checkOutput("auto_done_idx", obs_done_idx, 106);
    checkOutput("auto_trig_addr", trig_addr, 6);
    endAcq();

    c_pre = 10; c_post = 2; c_level = 8'h80; c_rising = 1'b1; c_auto = 1'b0; c_tmo = 0;
    clearStim();
    for (int i = 1; i <= 45; i++) begin s_vld[i] = 1'b1; s_dat[i] = (i == 37) ? 8'h90 : 8'h00; end
    runAcq("wrap", 45);
    checkOutput("wrap_trig_addr", trig_addr, 4);
    endAcq();

    // Arm while waiting and force during the pre window must both be ignored.
    c_pre = 2; c_post = 2; c_level = 8'h80; c_rising = 1'b1; c_auto = 1'b0; c_tmo = 0;
    clearStim();
    for (int i = 1; i <= 12; i++) begin s_vld[i] = 1'b1; s_dat[i] = (i == 7) ? 8'h90 : 8'h10; end
    s_frc[1] = 1'b1; s_arm[4] = 1'b1;
    runAcq("ign", 12);
    checkOutput("ign_trig_addr", trig_addr, 6);
    checkOutput("ign_done_idx", obs_done_idx, 9);

    c_pre = 0; c_post = 1;
    clearStim();
    for (int i = 1; i <= 4; i++) begin s_vld[i] = 1'b1; s_dat[i] = 8'h10; end
    s_frc[2] = 1'b1;
    runAcq("rearm", 4);
    checkOutput("rearm_trig_addr", trig_addr, 1);
    checkOutput("rearm_first_addr", (obs_q.size() > 0) ? obs_q[0].addr : -1, 0);

    rst = 1'b1;
    tick();
    checkOutput("rst2_done", done, 0);
    checkOutput("rst2_trig_addr", trig_addr, 0);
    checkOutput("rst2_wr_addr", wr_addr, 0);
    rst = 1'b0;

    // Abort during the post window.
    c_pre = 0; c_post = 8; c_level = 8'h80; c_rising = 1'b1; c_auto = 1'b0; c_tmo = 0;
    driveConfig();
    tick(); arm = 1'b1;
    tick(); arm = 1'b0; adc_valid = 1'b1; adc_data = 8'h11; trig_force = 1'b1;
    tick(); trig_force = 1'b0; adc_data = 8'h12;
    checkOutput("post_busy", busy, 1);
    checkOutput("post_wr_en", wr_en, 1);
    tick(); adc_data = 8'h13; abort = 1'b1;
    tick(); abort = 1'b0;
    checkOutput("abort_post_busy", busy, 0);
    checkOutput("abort_post_done", done, 0);
    checkOutput("abort_post_wr_en", wr_en, 0);
    wcount = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (wr_en) wcount++; end
    checkOutput("abort_post_no_writes", wcount, 0);

    tick(); arm = 1'b1; abort = 1'b1;
    tick(); arm = 1'b0; abort = 1'b0;
    checkOutput("armabort_idle_busy", busy, 0);
    pre_len = 4'd5; arm = 1'b1;
    tick(); arm = 1'b0;
    checkOutput("arm_pre_busy", busy, 1);
    tick(); tick(); arm = 1'b1; abort = 1'b1;
    tick(); arm = 1'b0; abort = 1'b0;
    checkOutput("armabort_busy_busy", busy, 0);
    checkOutput("armabort_busy_done", done, 0);
    tick();
    checkOutput("armabort_busy_wr_en", wr_en, 0);
    idleInputs();

    c_pre = 0; c_post = 0;
    clearStim();
    s_vld[1] = 1'b1; s_dat[1] = 8'h22; s_frc[1] = 1'b1;
    runAcq("todone", 3);
    arm = 1'b1; abort = 1'b1;
    tick(); arm = 1'b0; abort = 1'b0;
    checkOutput("armabort_done_done", done, 0);
    checkOutput("armabort_done_busy", busy, 0);

    for (int r = 0; r < 25; r++) begin
      c_pre = $urandom_range(0, 6); c_post = $urandom_range(0, 6);
      c_level = 8'($urandom); c_rising = 1'($urandom_range(0, 1));
      c_auto = 1'($urandom_range(0, 1)); c_tmo = $urandom_range(0, 60);
      clearStim();
      for (int i = 1; i <= 120; i++) begin
        s_vld[i] = ($urandom_range(0, 3) != 0);
        s_dat[i] = 8'($urandom);
        s_frc[i] = ($urandom_range(0, 49) == 0);
      end
      runAcq("rnd", 120);
      endAcq();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
